// File: rtl/vec_dot_product_stream_packer_pkg.sv
// Shared definitions for the dot-product stream packer: default geometry,
// downstream result widths and the packer FSM state encoding.
package vec_dot_product_stream_packer_pkg;

    localparam int N_DEFAULT = 8;
    localparam int W_DEFAULT = 8;

    // Widths used by the dot-product cores fed by the packer.
    localparam int PROD_W  = 2 * W_DEFAULT;
    localparam int SUM_W   = 2 * W_DEFAULT + $clog2(N_DEFAULT);
    localparam int COUNT_W = $clog2(N_DEFAULT + 1);

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_e;

    // Lane-index width; never zero even for degenerate lane counts.
    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/vec_dot_product_stream_packer.sv
// Packs (a_k, b_k) element pairs into N-lane vectors (lane 0 in the LSBs),
// zero-pads short vectors ended by in_last and hands them downstream.
module vec_dot_product_stream_packer
    import vec_dot_product_stream_packer_pkg::*;
#(
    parameter int N = N_DEFAULT,
    parameter int W = W_DEFAULT
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [W-1:0]             in_a,
    input  logic [W-1:0]             in_b,
    input  logic                     in_last,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [N*W-1:0]           vec_a,
    output logic [N*W-1:0]           vec_b,
    output logic [$clog2(N+1)-1:0]   out_count,
    output state_e                   dbg_state
);

    localparam int CNT_W = $clog2(N + 1);
    localparam int IDX_W = idx_width(N);

    // Handshakes: a transfer happens on a rising edge where valid && ready are
    // both high; a producer holds valid and data steady until that edge, and
    // ready never depends combinationally on the same port's valid.

    state_e             state;
    state_e             state_nxt;
    logic [IDX_W-1:0]   idx;
    logic [N*W-1:0]     buf_a;
    logic [N*W-1:0]     buf_b;
    logic [N*W-1:0]     fill_a;
    logic [N*W-1:0]     fill_b;
    logic               accept;
    logic               last_lane;
    logic               complete;
    logic               handoff;

    assign accept    = in_valid && in_ready;
    assign last_lane = (idx == IDX_W'(N - 1));
    assign complete  = accept && (last_lane || in_last);
    assign handoff   = out_valid && out_ready;
    assign dbg_state = state;

    // Build buffer with the element being accepted merged into lane idx.
    always_comb begin
        fill_a = buf_a;
        fill_b = buf_b;
        for (int k = 0; k < N; k++) begin
            if (idx == IDX_W'(k)) begin
                fill_a[k*W +: W] = in_a;
                fill_b[k*W +: W] = in_b;
            end
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= FILL;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic. In HOLD an accept can only happen together with the
    // handoff, so a completing accept there reloads the output and stays.
    always_comb begin
        state_nxt = state;
        unique case (state)
            FILL: begin
                if (complete) begin
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (handoff && !complete) begin
                    state_nxt = FILL;
                end
            end
            default: state_nxt = FILL;
        endcase
    end

    // Output logic; in_ready is forced low while reset is asserted.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (state)
            FILL: begin
                in_ready = !rst;
            end
            HOLD: begin
                in_ready  = !rst && out_ready;
                out_valid = 1'b1;
            end
            default: begin
                in_ready  = 1'b0;
                out_valid = 1'b0;
            end
        endcase
    end

    // Build buffer: cleared whenever a vector completes so unwritten lanes stay 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf_a <= '0;
            buf_b <= '0;
            idx   <= '0;
        end else if (complete) begin
            buf_a <= '0;
            buf_b <= '0;
            idx   <= '0;
        end else if (accept) begin
            buf_a <= fill_a;
            buf_b <= fill_b;
            idx   <= idx + IDX_W'(1);
        end
    end

    // Output registers only load on completion, so they are stable through HOLD.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vec_a     <= '0;
            vec_b     <= '0;
            out_count <= '0;
        end else if (complete) begin
            vec_a     <= fill_a;
            vec_b     <= fill_b;
            out_count <= CNT_W'(idx) + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_vec_dot_product_stream_packer.sv
// Directed bench for the dot-product stream packer: table-driven vectors plus
// hand sequences for backpressure, back-to-back streaming and mid-fill reset.
module tb_vec_dot_product_stream_packer;
    import vec_dot_product_stream_packer_pkg::*;

    localparam int N     = 8;
    localparam int W     = 8;
    localparam int OUT_W = 4 + 2 * N * W;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [7:0]   in_a;
    logic [7:0]   in_b;
    logic         in_last;
    logic         out_valid;
    logic         out_ready;
    logic [63:0]  vec_a;
    logic [63:0]  vec_b;
    logic [3:0]   out_count;
    state_e       dbg_state;

    int checks = 0;
    int errors = 0;
    logic [OUT_W-1:0] exp_q[$];

    vec_dot_product_stream_packer #(.N(N), .W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .vec_a     (vec_a),
        .vec_b     (vec_b),
        .out_count (out_count),
        .dbg_state (dbg_state)
    );

    // Clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        int          n_elem;
        logic        use_last;
        logic [63:0] stim_a;
        logic [63:0] stim_b;
        logic [63:0] exp_a;
        logic [63:0] exp_b;
        logic [3:0]  exp_count;
        logic [18:0] exp_dot;
    } vec_rec_t;

    vec_rec_t tbl[5];

    task automatic check(input string name, input logic [OUT_W-1:0] got, input logic [OUT_W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic logic [18:0] dot8(input logic [63:0] a, input logic [63:0] b);
        logic [18:0] acc;
        acc = '0;
        for (int k = 0; k < 8; k++) begin
            acc = acc + 19'(a[k*8 +: 8] * b[k*8 +: 8]);
        end
        return acc;
    endfunction

    // Driver tasks
    task automatic send_elem(input logic [7:0] a, input logic [7:0] b, input logic last,
                             output int stalls);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_last  = last;
        stalls   = 0;
        #1;
        while (!in_ready && stalls < 50) begin
            @(posedge clk);
            #1;
            stalls++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got in_ready 0 expected 1 within 50 cycles");
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic do_handoff();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        #1;
        check("out_valid_after_handoff", OUT_W'(out_valid), OUT_W'(0));
    endtask

    task automatic check_held(input string tag, input logic [63:0] ea, input logic [63:0] eb,
                              input logic [3:0] ec);
        check({tag, "_out_valid"}, OUT_W'(out_valid), OUT_W'(1));
        check({tag, "_vec_a"}, OUT_W'(vec_a), OUT_W'(ea));
        check({tag, "_vec_b"}, OUT_W'(vec_b), OUT_W'(eb));
        check({tag, "_out_count"}, OUT_W'(out_count), OUT_W'(ec));
    endtask

    // Scoreboard: every handoff must match the head of the expected queue.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_handoff: got count %0d vec_a %h expected no output",
                         out_count, vec_a);
            end else begin
                check("handoff", {out_count, vec_b, vec_a}, exp_q.pop_front());
            end
        end
    end

    initial begin
        int st;
        int total_stalls;

        tbl[0] = '{8, 1'b0, 64'h0807060504030201, 64'h0202020202020202,
                   64'h0807060504030201, 64'h0202020202020202, 4'd8, 19'd72};
        tbl[1] = '{3, 1'b1, 64'hDEADBEEF00FFFFFF, 64'h1234567800FFFFFF,
                   64'h0000000000FFFFFF, 64'h0000000000FFFFFF, 4'd3, 19'd195075};
        tbl[2] = '{1, 1'b1, 64'h555555555555557F, 64'hAAAAAAAAAAAAAA03,
                   64'h000000000000007F, 64'h0000000000000003, 4'd1, 19'd381};
        tbl[3] = '{8, 1'b1, 64'h8070605040302010, 64'h0807060504030201,
                   64'h8070605040302010, 64'h0807060504030201, 4'd8, 19'd3264};
        tbl[4] = '{5, 1'b1, 64'h9999990504030201, 64'h7777770102030405,
                   64'h0000000504030201, 64'h0000000102030405, 4'd5, 19'd35};

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;

        #2;
        check("reset_in_ready", OUT_W'(in_ready), OUT_W'(0));
        check("reset_out_valid", OUT_W'(out_valid), OUT_W'(0));
        check("reset_vec_a", OUT_W'(vec_a), OUT_W'(0));
        check("reset_vec_b", OUT_W'(vec_b), OUT_W'(0));
        check("reset_out_count", OUT_W'(out_count), OUT_W'(0));
        check("reset_state", OUT_W'(dbg_state), OUT_W'(FILL));
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("post_reset_in_ready", OUT_W'(in_ready), OUT_W'(1));

        // Table-driven vectors, output held by backpressure then handed off.
        for (int i = 0; i < 5; i++) begin
            for (int e = 0; e < tbl[i].n_elem; e++) begin
                send_elem(tbl[i].stim_a[e*8 +: 8], tbl[i].stim_b[e*8 +: 8],
                          tbl[i].use_last && (e == tbl[i].n_elem - 1), st);
                check("fill_no_stall", OUT_W'(st), OUT_W'(0));
            end
            idle();
            check_held($sformatf("tbl%0d", i), tbl[i].exp_a, tbl[i].exp_b, tbl[i].exp_count);
            check($sformatf("tbl%0d_dot", i), OUT_W'(dot8(vec_a, vec_b)), OUT_W'(tbl[i].exp_dot));
            exp_q.push_back({tbl[i].exp_count, tbl[i].exp_b, tbl[i].exp_a});
            do_handoff();
        end

        // Backpressure: hold for 5 cycles with a new element waiting.
        out_ready = 1'b0;
        send_elem(8'h31, 8'h41, 1'b0, st);
        send_elem(8'h32, 8'h42, 1'b0, st);
        send_elem(8'h33, 8'h43, 1'b0, st);
        send_elem(8'h34, 8'h44, 1'b1, st);
        exp_q.push_back({4'd4, 64'h0000000044434241, 64'h0000000034333231});
        in_valid = 1'b1;
        in_a     = 8'hC1;
        in_b     = 8'hD1;
        in_last  = 1'b0;
        for (int c = 0; c < 5; c++) begin
            #1;
            check("bp_in_ready", OUT_W'(in_ready), OUT_W'(0));
            check_held("bp", 64'h0000000034333231, 64'h0000000044434241, 4'd4);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        #1;
        check("bp_release_in_ready", OUT_W'(in_ready), OUT_W'(1));
        @(posedge clk);
        #1;
        idle();
        out_ready = 1'b0;
        #1;
        check("bp_after_out_valid", OUT_W'(out_valid), OUT_W'(0));
        check("bp_after_state", OUT_W'(dbg_state), OUT_W'(FILL));
        send_elem(8'hC2, 8'hD2, 1'b1, st);
        idle();
        check_held("bp_next", 64'h000000000000C2C1, 64'h000000000000D2D1, 4'd2);
        exp_q.push_back({4'd2, 64'h000000000000D2D1, 64'h000000000000C2C1});
        do_handoff();

        // Back-to-back: 24 elements with continuous valid and ready.
        out_ready = 1'b1;
        exp_q.push_back({4'd8, 64'hA7A6A5A4A3A2A1A0, 64'h0807060504030201});
        exp_q.push_back({4'd8, 64'hAFAEADACABAAA9A8, 64'h100F0E0D0C0B0A09});
        exp_q.push_back({4'd8, 64'hB7B6B5B4B3B2B1B0, 64'h1817161514131211});
        total_stalls = 0;
        for (int k = 0; k < 24; k++) begin
            send_elem(8'(k + 1), 8'(8'hA0 + k), 1'b0, st);
            total_stalls += st;
        end
        idle();
        check("b2b_total_stalls", OUT_W'(total_stalls), OUT_W'(0));
        for (int c = 0; c < 10 && exp_q.size() != 0; c++) begin
            @(posedge clk);
            #1;
        end
        check("b2b_queue_drained", OUT_W'(exp_q.size()), OUT_W'(0));
        out_ready = 1'b0;
        #1;
        check("b2b_idle_out_valid", OUT_W'(out_valid), OUT_W'(0));

        // Reset mid-fill discards the partial vector and clears the outputs.
        send_elem(8'hE1, 8'hF1, 1'b0, st);
        send_elem(8'hE2, 8'hF2, 1'b0, st);
        send_elem(8'hE3, 8'hF3, 1'b0, st);
        send_elem(8'hE4, 8'hF4, 1'b0, st);
        idle();
        #1;
        rst = 1'b1;
        #1;
        check("rst_mid_in_ready", OUT_W'(in_ready), OUT_W'(0));
        check("rst_mid_out_valid", OUT_W'(out_valid), OUT_W'(0));
        check("rst_mid_vec_a", OUT_W'(vec_a), OUT_W'(0));
        check("rst_mid_vec_b", OUT_W'(vec_b), OUT_W'(0));
        check("rst_mid_out_count", OUT_W'(out_count), OUT_W'(0));
        check("rst_mid_state", OUT_W'(dbg_state), OUT_W'(FILL));
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            send_elem(8'(8'h11 * (k + 1)), 8'h01, 1'b0, st);
        end
        idle();
        check_held("rst_clean", 64'h8877665544332211, 64'h0101010101010101, 4'd8);
        check("rst_clean_dot", OUT_W'(dot8(vec_a, vec_b)), OUT_W'(612));
        exp_q.push_back({4'd8, 64'h0101010101010101, 64'h8877665544332211});
        do_handoff();

        repeat (2) @(posedge clk);
        #1;
        check("final_queue_empty", OUT_W'(exp_q.size()), OUT_W'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/vec_dot_product_stream_packer.md
# vec_dot_product_stream_packer

Streaming front end for the team's 8-lane unsigned dot-product datapath. It accepts element pairs (a_k, b_k) one per cycle over a valid/ready handshake. It packs them into the lane layout the dot-product cores consume: element k sits in bits [k*W +: W] of vec_a and vec_b. It then presents the completed vector pair downstream over a second valid/ready handshake. Short vectors terminated by in_last are zero-padded, so the downstream sum is unaffected.

## Interface
- N, default 8: lanes per vector, N >= 2.
- W, default 8: element width in bits, unsigned.
- clk  in  1  rising-edge clock.
- rst  in  1  reset; asynchronous, active-high.
- in_valid  in  1  element pair offered.
- in_ready  out  1  packer can accept this cycle.
- in_a  in  W  element of vector A.
- in_b  in  W  element of vector B.
- in_last  in  1  final element of the current vector.
- out_valid  out  1  packed vector pair available.
- out_ready  in  1  downstream takes the pair this cycle.
- vec_a  out  N*W  packed vector A, lane 0 in LSBs.
- vec_b  out  N*W  packed vector B.
- out_count  out  $clog2(N+1)  number of real elements in the pair, 1..N.

## Operation
- The FSM has two states, FILL and HOLD. The reset state is FILL with idx = 0.
- Accept means in_valid && in_ready.
- FILL:
  - in_ready = 1.
  - An accept writes in_a/in_b into lane idx of the build buffer and increments idx.
  - If idx == N-1 or in_last is set, the buffer transfers to the output registers, out_count is set to idx+1, and the FSM goes to HOLD. The next build buffer starts all-zero with idx = 0.
- HOLD:
  - out_valid = 1.
  - vec_a, vec_b and out_count are stable until handoff (out_valid && out_ready).
  - in_ready = out_ready. An accept in the handoff cycle writes lane 0 of the new buffer, so there is no bubble.
  - On handoff, the FSM returns to FILL, unless the same-cycle accept also completes a vector (in_last, or N == 1-equivalent). In that case it stays in HOLD and loads the new output immediately.
- Unwritten lanes are always 0, so a downstream sum of products is correct for short vectors.
- in_last on the first element gives out_count = 1, with only lane 0 nonzero.
- in_last on the N-th element is the same as a natural full vector; it does not produce an extra empty vector.
- No data is dropped or duplicated under any valid/ready pattern.
- Inputs are ignored while in_valid = 0.
- Reset mid-operation discards the partial build buffer and any held output.

## Timing
- While rst is asserted, all outputs are 0: out_valid 0, vec_a 0, vec_b 0, out_count 0, in_ready 0. The FSM state is FILL and idx is 0.
- in_ready is combinational from state and out_ready. There is no combinational path from in_valid to in_ready.
- Latency: out_valid rises on the cycle after the completing accept.
- Throughput: one element per cycle sustained when out_ready = 1. A full vector is produced every N cycles.
- Backpressure: with out_ready = 0 in HOLD, in_ready = 0 and the outputs hold indefinitely.

## Structure
- Shared package holds:
  - lane count and element width defaults;
  - PROD_W = 2*W and SUM_W = 2*W + $clog2(N), which is 19 for the defaults and is the downstream result width;
  - COUNT_W = $clog2(N+1);
  - the state enum {FILL, HOLD}.
- Single module. No sub-module is warranted: lane write-enable decode and the output register are too small to split out.

## Test plan
- Full vector, out_ready = 1: stream a = 1..8 and b = 2 on every element. Required: out_valid one cycle after the 8th accept, vec_a = 64'h0807060504030201, vec_b = 64'h0202020202020202, out_count = 8. Downstream dot product = 72.
- Short vector: 3 elements a = {0xFF, 0xFF, 0xFF}, b = {0xFF, 0xFF, 0xFF} with in_last on the 3rd. Required: vec_a = vec_b = 64'h0000000000FFFFFF, out_count = 3, dot product = 195075.
- Backpressure: complete a vector while out_ready = 0 for 5 cycles. Required: in_ready = 0 and outputs stable for all 5 cycles. When out_ready rises, a single handoff occurs, then FILL resumes.
- Back-to-back: continuous in_valid = 1 and out_ready = 1 for 24 elements. Required: 3 vectors, no idle cycles on in_ready, and the first element of each subsequent vector lands in lane 0.
- Reset mid-fill: after 4 accepts, assert rst asynchronously. Required: outputs 0 immediately. After release, the next 8 elements form a clean vector with no residue from the first 4.
- in_last on element 1 with a = 0x7F, b = 0x03. Required: vec_a = 64'h7F, vec_b = 64'h03, out_count = 1.
